// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
// Load hits return combinationally; load misses refill a full line over the
// req/ack bus; stores always write through. Optional hit/miss counters are
// compiled in when DCACHE_STATS_EN is defined.
module data_cache #(
  parameter int DATA_WIDTH     = 32,
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [31:0]             cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0] cpu_be,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
`endif
);

  localparam int WB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(SETS);
  localparam int TB = 32 - IB - WB - 2;
  localparam int unsigned LANES = DATA_WIDTH / 8;
  localparam logic [WB-1:0] LAST = WB'(WORDS_PER_LINE - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0]            state;
  logic [WB-1:0]         counter;
  logic [WB-1:0]         counter_nx;
  logic [SETS-1:0]       valid;
  logic [TB-1:0]         tag_mem  [SETS];
  logic [DATA_WIDTH-1:0] data_mem [SETS*WORDS_PER_LINE];

  logic [IB-1:0] idx;
  logic [WB-1:0] word;
  logic [TB-1:0] tag;
  logic          hit;
  logic          load_hit;
  logic          fill_done;
  logic          unused_bits;

  assign idx         = cpu_addr[IB+WB+1:WB+2];
  assign word        = cpu_addr[WB+1:2];
  assign tag         = cpu_addr[31:IB+WB+2];
  assign unused_bits = ^cpu_addr[1:0];
  assign counter_nx  = counter + WB'(1);
  assign hit         = valid[idx] && (tag_mem[idx] == tag);
  assign load_hit    = (state == IDLE) && cpu_req && !cpu_we && hit;
  assign fill_done   = (state == FILL) && mem_ack && (counter == LAST);

  // Load data and pipeline freeze, both combinational on the current access
  always_comb begin
    cpu_rdata = '0;
    stall     = 1'b0;
    if (load_hit) cpu_rdata = data_mem[{idx, word}];
    case (state)
      IDLE:    stall = cpu_req && (cpu_we || !hit);
      FILL:    stall = 1'b1;
      WRITE:   stall = !mem_ack;
      default: stall = 1'b0;
    endcase
  end

  // Control FSM, valid bits and the registered backing-memory bus
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      counter   <= '0;
      valid     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req && cpu_we) begin
            state     <= WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {cpu_addr[31:2], 2'b00};
            mem_wdata <= cpu_wdata;
            mem_be    <= cpu_be;
          end else if (cpu_req && !hit) begin
            state      <= FILL;
            counter    <= '0;
            valid[idx] <= 1'b0;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= {cpu_addr[31:WB+2], {WB{1'b0}}, 2'b00};
          end
        end
        FILL: begin
          if (mem_ack) begin
            if (counter == LAST) begin
              state      <= IDLE;
              counter    <= '0;
              valid[idx] <= 1'b1;
              mem_req    <= 1'b0;
              mem_addr   <= '0;
            end else begin
              counter  <= counter_nx;
              mem_addr <= {cpu_addr[31:WB+2], counter_nx, 2'b00};
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays: refill words, and write-through merge on store hits
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == FILL && mem_ack) begin
        data_mem[{idx, counter}] <= mem_rdata;
        if (counter == LAST) tag_mem[idx] <= tag;
      end
      if (state == WRITE && mem_ack && hit) begin
        for (int unsigned b = 0; b < LANES; b++) begin
          if (cpu_be[b]) data_mem[{idx, word}][8*b +: 8] <= cpu_wdata[8*b +: 8];
        end
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic from_fill;

  // Hit/miss counters; the hit cycle that closes a refill is not a real hit
  always_ff @(posedge clk) begin
    if (rst) begin
      from_fill  <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      from_fill <= fill_done;
      if (load_hit && !from_fill) hit_count <= hit_count + 32'd1;
      if (state == IDLE && cpu_req && !cpu_we && !hit) miss_count <= miss_count + 32'd1;
    end
  end
`else
  logic unused_fill;
  assign unused_fill = fill_done;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: stimulus pushes expected bus transactions
// and load results; monitors pop and compare when the DUT presents them.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  data_cache #(.DATA_WIDTH(32), .SETS(64), .WORDS_PER_LINE(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_rdata(cpu_rdata),
    .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_txn_t;

  mem_txn_t    exp_mem[$];
  logic [31:0] exp_load[$];
  logic [31:0] mem_model [logic [31:0]];
  int          nassert = 0;
  int          nfail   = 0;
  int          lat     = 1;
  int          cnt     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nassert++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Backing memory: acks after lat cycles of mem_req, applies writes
  always @(posedge clk) begin
    #1;
    if (mem_req && !rst) begin
      cnt++;
      if (cnt >= lat) begin
        logic [31:0] tmp;
        mem_ack = 1'b1;
        cnt = 0;
        tmp = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) tmp[8*b +: 8] = mem_wdata[8*b +: 8];
          mem_model[mem_addr] = tmp;
        end else begin
          mem_rdata = tmp;
        end
      end else begin
        mem_ack = 1'b0;
      end
    end else begin
      cnt = 0;
      mem_ack = 1'b0;
    end
  end

  // Monitor: bus transactions and completed loads against the scoreboard
  always @(negedge clk) begin
    if (mem_req && mem_ack) begin
      if (exp_mem.size() == 0) begin
        check("mem_unexpected_txn", mem_addr, 32'hFFFF_FFFF);
      end else begin
        mem_txn_t t;
        t = exp_mem.pop_front();
        check("mem_we", {31'd0, mem_we}, {31'd0, t.we});
        check("mem_addr", mem_addr, t.addr);
        if (t.we) begin
          check("mem_wdata", mem_wdata, t.wdata);
          check("mem_be", {28'd0, mem_be}, {28'd0, t.be});
        end
      end
    end
    if (!rst && cpu_req && !cpu_we && !stall) begin
      if (exp_load.size() == 0) check("load_unexpected", cpu_rdata, 32'hFFFF_FFFF);
      else check("cpu_rdata", cpu_rdata, exp_load.pop_front());
    end
  end

  task automatic push_fill(input logic [31:0] base);
    for (int w = 0; w < 4; w++) begin
      mem_txn_t t;
      t.we = 1'b0; t.addr = base + 32'(4 * w); t.wdata = '0; t.be = '0;
      exp_mem.push_back(t);
    end
  endtask

  // Called just after a posedge; returns just after the completing posedge
  task automatic do_load(input logic [31:0] a, input logic [31:0] d, input int exp_st);
    int st;
    st = 0;
    exp_load.push_back(d);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a; cpu_wdata = '0; cpu_be = '0;
    @(negedge clk);
    while (stall && st < 200) begin
      st++;
      @(negedge clk);
    end
    check($sformatf("load_stall_cycles_%0h", a), 32'(st), 32'(exp_st));
    if (exp_st == 0) check("hit_no_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          input int exp_st);
    int st;
    mem_txn_t t;
    t.we = 1'b1; t.addr = a; t.wdata = d; t.be = be;
    exp_mem.push_back(t);
    st = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_be = be;
    @(negedge clk);
    while (stall && st < 200) begin
      st++;
      @(negedge clk);
    end
    check($sformatf("store_stall_cycles_%0h", a), 32'(st), 32'(exp_st));
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acks;
    mem_model[32'h1000] = 32'h11; mem_model[32'h1004] = 32'h22;
    mem_model[32'h1008] = 32'h33; mem_model[32'h100C] = 32'h44;
    mem_model[32'h2000] = 32'h55; mem_model[32'h2004] = 32'h66;
    mem_model[32'h2008] = 32'h77; mem_model[32'h200C] = 32'h88;
    mem_model[32'h3000] = 32'h99; mem_model[32'h3004] = 32'hAA;
    mem_model[32'h3008] = 32'hBB; mem_model[32'h300C] = 32'hCC;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;

    // Line fill with ack latency 2, then a hit in the same line
    lat = 2;
    push_fill(32'h1000);
    do_load(32'h1000, 32'h11, 9);
    do_load(32'h1008, 32'h33, 0);
`ifdef DCACHE_STATS_EN
    check("hit_count", hit_count, 32'd1);
    check("miss_count", miss_count, 32'd1);
`endif

    // Store hits: full word then a single byte, merged into the cached word
    lat = 1;
    do_store(32'h1004, 32'hDEADBEEF, 4'b1111, 1);
    do_store(32'h1004, 32'h000000AB, 4'b0001, 1);
    do_load(32'h1004, 32'hDEADBEAB, 0);

    // Store miss allocates nothing; the later load refills the line
    do_store(32'h3000, 32'h00000005, 4'b1111, 1);
    push_fill(32'h3000);
    do_load(32'h3000, 32'h00000005, 5);

    // Conflicting tags on index 0
    push_fill(32'h1000);
    do_load(32'h1000, 32'h11, 5);
    lat = 3;
    push_fill(32'h2000);
    do_load(32'h2000, 32'h55, 13);
    lat = 1;
    push_fill(32'h1000);
    do_load(32'h1000, 32'h11, 5);
    do_load(32'h1004, 32'hDEADBEAB, 0);

    // Reset after the second fill ack abandons the refill
    lat = 2;
    begin
      mem_txn_t t;
      t.we = 1'b0; t.wdata = '0; t.be = '0;
      t.addr = 32'h2000; exp_mem.push_back(t);
      t.addr = 32'h2004; exp_mem.push_back(t);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h2008;
    acks = 0;
    for (int i = 0; i < 100 && acks < 2; i++) begin
      @(negedge clk);
      if (mem_req && mem_ack) acks++;
    end
    check("abort_ack_count", 32'(acks), 32'd2);
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_mem_req", {31'd0, mem_req}, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_cpu_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    lat = 1;
    push_fill(32'h1000);
    do_load(32'h1000, 32'h11, 5);

    repeat (2) @(posedge clk);
    check("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
    check("exp_load_drained", 32'(exp_load.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
